rom_port_arbiter: RTL
=====================

Name: rom_port_arbiter

Overview:
- Single-port arbiter/sequencer in front of the instruction ROM.
- Shares the ROM's one address/write port between two requesters:
  - the core's instruction-fetch path (read-only, combinational read);
  - a debug/program loader (read/write, request/grant plus per-access valid/ack).
- Stalls the core while the loader owns the ROM.
- Pulses a core restart after a load session that wrote the ROM.
- Sits between the fetch stage, the loader (UART/JTAG bridge) and the ROM.

Parameters:
- HOLD_CYCLES, 2: cycles core_hold_o is asserted before ld_gnt_o rises, so in-flight fetches drain. Legal range 1..15.
- RST_CYCLES, 4: length of the core_rst_o pulse at session end. Legal range 1..15.
- ROM_NUM, 4096: ROM depth in 32-bit words; used for the loader bounds check.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- core_addr_i  in  32  fetch byte address
- core_data_o  out  32  fetch instruction word
- core_hold_o  out  1  stall request to the pipeline
- core_rst_o  out  1  core restart pulse (PC back to reset vector)
- ld_req_i  in  1  loader session request; level, held for the whole session
- ld_gnt_o  out  1  loader owns the ROM
- ld_valid_i  in  1  loader access strobe, one cycle per access
- ld_we_i  in  1  1 = write, 0 = read
- ld_addr_i  in  32  loader byte address
- ld_wdata_i  in  32  loader write data
- ld_ack_o  out  1  access complete, registered
- ld_err_o  out  1  access rejected; valid with ld_ack_o
- ld_rdata_o  out  32  read data; valid with ld_ack_o
- ld_wr_cnt_o  out  16  writes accepted in the current/last session
- rom_we_o  out  1  to ROM write enable
- rom_addr_o  out  32  to ROM address
- rom_wdata_o  out  32  to ROM write data
- rom_rdata_i  in  32  from ROM read data (combinational)

Behaviour:
- Reset values:
  - state = S_CORE; all 1-bit outputs 0.
  - ld_rdata_o = 0, ld_wr_cnt_o = 0.
  - Internal hold/reset counters = 0.
- Reset mid-session aborts the session immediately: no pending write completes and no ack is issued.
- ROM port mux (combinational, from state):
  - S_LOADER: rom_addr_o = ld_addr_i; rom_wdata_o = ld_wdata_i.
  - All other states: rom_addr_o = core_addr_i.
  - rom_we_o = 1 only when state = S_LOADER, ld_valid_i = 1, ld_we_i = 1 and the address is legal; otherwise 0.
- core_data_o:
  - Equals rom_rdata_i in S_CORE.
  - Equals 32'h0000_0013 (NOP) in every other state.
- FSM transitions:
  - S_CORE → S_DRAIN when ld_req_i = 1.
  - S_DRAIN: core_hold_o = 1; the counter counts HOLD_CYCLES cycles, then the FSM moves to S_LOADER. ld_wr_cnt_o clears on entry to S_DRAIN.
  - S_LOADER: core_hold_o = 1 and ld_gnt_o = 1.
    - When ld_req_i = 0, go to S_RELEASE. ld_valid_i in that same cycle is ignored: no write, no ack.
  - S_RELEASE: core_hold_o = 1 and ld_gnt_o = 0.
    - If ld_wr_cnt_o > 0: core_rst_o = 1 for RST_CYCLES cycles, then go to S_CORE.
    - Otherwise: spend 1 cycle in S_RELEASE with no reset pulse, then go to S_CORE.
    - ld_req_i re-asserted during S_RELEASE is ignored until S_CORE is reached. From S_CORE it takes the normal path to S_DRAIN.
- Loader access rules:
  - Legal address: ld_addr_i[1:0] == 0 and ld_addr_i[31:2] < ROM_NUM.
  - ld_ack_o is asserted for exactly one cycle, the cycle after an accepted ld_valid_i.
  - ld_rdata_o is registered from rom_rdata_i for reads; it holds its value otherwise.
  - Illegal address: no write; ld_err_o = 1 with the ack; ld_rdata_o = 0.
  - ld_valid_i outside S_LOADER: ignored, no ack.
- ld_wr_cnt_o:
  - Increments on each accepted write.
  - Saturates at 16'hFFFF.
  - Holds its value after the session ends.
- Back-to-back ld_valid_i on consecutive cycles is supported, one ack per access.

Decomposition:
- Shared defines file: reuse the existing MemAddrBus, MemBus, ZeroWord, WriteEnable and RstEnable macros.
- Add to the same defines file: the NOP encoding, and the state encodings S_CORE/S_DRAIN/S_LOADER/S_RELEASE (2 bits).
- Single module. No sub-module; the two small counters stay inline.

Test Plan:
- Reset, then core_addr_i = 0x8 with ROM[2] = 0xDEADBEEF → core_data_o = 0xDEADBEEF; core_hold_o = 0, ld_gnt_o = 0, rom_we_o = 0.
- ld_req_i rises at cycle T → core_hold_o = 1 at T+1; ld_gnt_o = 1 at T+1+HOLD_CYCLES (T+3 with the default); core_data_o = 0x00000013 throughout.
- In S_LOADER: write 0x12345678 to 0x10, then read 0x10 on the next cycle → ROM[4] updated; two ack pulses; second ack has ld_rdata_o = 0x12345678; ld_wr_cnt_o = 1.
- Writes to 0x6 (unaligned) and to ROM_NUM*4 (out of range) → rom_we_o stays 0; ld_ack_o = 1 with ld_err_o = 1; ld_wr_cnt_o unchanged.
- ld_req_i drops after 3 writes → core_rst_o high for exactly 4 cycles, then core_hold_o = 0 and core_data_o tracks the ROM again. A read-only session → no core_rst_o pulse, release takes 1 cycle.
- rst asserted mid-write-session → next cycle: all outputs 0, state S_CORE, no ack for the pending access.

Source files
------------

// File: rtl/rom_port_arbiter_pkg.sv
// Shared widths, constants and FSM encodings for the instruction-ROM port arbiter.
package rom_port_arbiter_pkg;

    typedef logic [31:0] mem_addr_bus_t;
    typedef logic [31:0] mem_bus_t;

    localparam mem_bus_t ZERO_WORD    = 32'h0000_0000;
    localparam logic     WRITE_ENABLE = 1'b1;
    localparam logic     RST_ENABLE   = 1'b1;

    // addi x0, x0, 0 -- fed to the core whenever it does not own the ROM
    localparam mem_bus_t NOP = 32'h0000_0013;

    localparam logic [1:0] S_CORE    = 2'd0;
    localparam logic [1:0] S_DRAIN   = 2'd1;
    localparam logic [1:0] S_LOADER  = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

endpackage

// File: rtl/rom_port_arbiter.sv
// Shares the instruction ROM's single port between instruction fetch and a
// debug/program loader; stalls the core during a session and restarts it after writes.
module rom_port_arbiter
    import rom_port_arbiter_pkg::*;
#(
    parameter int HOLD_CYCLES = 2,
    parameter int RST_CYCLES  = 4,
    parameter int ROM_NUM     = 4096
) (
    input  logic          clk,
    input  logic          rst,
    input  mem_addr_bus_t core_addr_i,
    output mem_bus_t      core_data_o,
    output logic          core_hold_o,
    output logic          core_rst_o,
    input  logic          ld_req_i,
    output logic          ld_gnt_o,
    input  logic          ld_valid_i,
    input  logic          ld_we_i,
    input  mem_addr_bus_t ld_addr_i,
    input  mem_bus_t      ld_wdata_i,
    output logic          ld_ack_o,
    output logic          ld_err_o,
    output mem_bus_t      ld_rdata_o,
    output logic [15:0]   ld_wr_cnt_o,
    output logic          rom_we_o,
    output mem_addr_bus_t rom_addr_o,
    output mem_bus_t      rom_wdata_o,
    input  mem_bus_t      rom_rdata_i
);

    logic [1:0] state, state_nxt;
    logic [3:0] hold_cnt, rst_cnt;
    logic       addr_legal, access, wr_fire;

    assign addr_legal = (ld_addr_i[1:0] == 2'b00) &&
                        ({2'b00, ld_addr_i[31:2]} < 32'(ROM_NUM));

    // The cycle ld_req_i drops is already the end of the session, so its strobe is dropped.
    // rst also gates the strobe so a reset edge cannot commit a write to the external ROM.
    assign access  = (state == S_LOADER) && ld_req_i && ld_valid_i && (rst != RST_ENABLE);
    assign wr_fire = access && ld_we_i && addr_legal;

    assign rom_we_o    = wr_fire ? WRITE_ENABLE : ~WRITE_ENABLE;
    assign rom_addr_o  = (state == S_LOADER) ? ld_addr_i  : core_addr_i;
    assign rom_wdata_o = (state == S_LOADER) ? ld_wdata_i : ZERO_WORD;

    assign core_data_o = (state == S_CORE) ? rom_rdata_i : NOP;
    assign core_hold_o = (state != S_CORE);
    assign ld_gnt_o    = (state == S_LOADER);
    assign core_rst_o  = (state == S_RELEASE) && (ld_wr_cnt_o != 16'h0000);

    always_comb begin
        state_nxt = state;
        case (state)
            S_CORE:    if (ld_req_i) state_nxt = S_DRAIN;
            S_DRAIN:   if (hold_cnt == 4'(HOLD_CYCLES - 1)) state_nxt = S_LOADER;
            S_LOADER:  if (!ld_req_i) state_nxt = S_RELEASE;
            S_RELEASE: if ((ld_wr_cnt_o == 16'h0000) || (rst_cnt == 4'(RST_CYCLES - 1)))
                           state_nxt = S_CORE;
            default:   state_nxt = S_CORE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state    <= S_CORE;
            hold_cnt <= 4'd0;
            rst_cnt  <= 4'd0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= (state == S_DRAIN   && state_nxt == S_DRAIN)   ? hold_cnt + 4'd1 : 4'd0;
            rst_cnt  <= (state == S_RELEASE && state_nxt == S_RELEASE) ? rst_cnt  + 4'd1 : 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            ld_ack_o    <= 1'b0;
            ld_err_o    <= 1'b0;
            ld_rdata_o  <= ZERO_WORD;
            ld_wr_cnt_o <= 16'h0000;
        end else begin
            ld_ack_o <= access;
            ld_err_o <= access && !addr_legal;
            if (access && !addr_legal)
                ld_rdata_o <= ZERO_WORD;
            else if (access && !ld_we_i)
                ld_rdata_o <= rom_rdata_i;
            // Count restarts with each session; value survives release for the restart decision.
            if (state == S_CORE && ld_req_i)
                ld_wr_cnt_o <= 16'h0000;
            else if (wr_fire && ld_wr_cnt_o != 16'hFFFF)
                ld_wr_cnt_o <= ld_wr_cnt_o + 16'd1;
        end
    end

endmodule
